// File: rtl/lcd_capture_pkg.sv
// Shared configuration for the LCD capture front end: framebuffer geometry,
// FSM state encoding and counter widths.
package lcd_capture_pkg;

   localparam int COLLEN   = 75;
   localparam int ACTIVE_X = 224;
   localparam int ACTIVE_Y = 144;
   localparam int ADDR_W   = 14;
   localparam int PIX_W    = 12;

   // x is one bit wider than needed so overlong lines stay distinguishable
   // from exactly ACTIVE_X.
   localparam int X_W   = $clog2(ACTIVE_X + 1) + 1;
   localparam int Y_W   = $clog2(ACTIVE_Y + 1);
   localparam int COL_W = $clog2(COLLEN);

   typedef enum logic [1:0] {
      WAIT_VSYNC = 2'd0,
      WAIT_LINE  = 2'd1,
      ACTIVE     = 2'd2,
      FRAME_DONE = 2'd3
   } state_t;

   typedef logic [1:0] slice_t;

endpackage

// File: rtl/lcd_sync.sv
// Brings the asynchronous LCD bus into the pixel clock domain. Each control
// line gets a 2-flop synchronizer plus a third flop for edge detection; the
// detected events and the pixel word are registered once more so that they
// line up with each other.
module lcd_sync
   import lcd_capture_pkg::*;
#(
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             lcd_clk,
   input  logic             lcd_hsync,
   input  logic             lcd_vsync,
   input  logic [PIX_W-1:0] lcd_data,
   output logic             strobe,
   output logic             hsync_edge,
   output logic             vsync_edge,
   output logic [PIX_W-1:0] data
);

   // [0] first sync flop, [1] second sync flop, [2] edge-detect history
   logic [2:0]       clk_sr;
   logic [2:0]       hs_sr;
   logic [2:0]       vs_sr;
   logic [PIX_W-1:0] data_s1;
   logic [PIX_W-1:0] data_s2;

   // synchronizer chains and registered edge events
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sr     <= '0;
         hs_sr      <= {3{~HSYNC_POL}};
         vs_sr      <= {3{~VSYNC_POL}};
         data_s1    <= '0;
         data_s2    <= '0;
         strobe     <= 1'b0;
         hsync_edge <= 1'b0;
         vsync_edge <= 1'b0;
         data       <= '0;
      end else begin
         clk_sr     <= {clk_sr[1:0], lcd_clk};
         hs_sr      <= {hs_sr[1:0], lcd_hsync};
         vs_sr      <= {vs_sr[1:0], lcd_vsync};
         data_s1    <= lcd_data;
         data_s2    <= data_s1;
         strobe     <= clk_sr[1] & ~clk_sr[2];
         hsync_edge <= (hs_sr[1] == HSYNC_POL) && (hs_sr[2] != HSYNC_POL);
         vsync_edge <= (vs_sr[1] == VSYNC_POL) && (vs_sr[2] != VSYNC_POL);
         data       <= data_s2;
      end
   end

endmodule

// File: rtl/lcd_capture.sv
// LCD capture: packs the synchronized pixel stream into the 36-bit
// framebuffer (3 pixel slices per word, COLLEN words per line).
// Optional build macro LCD_CAPTURE_STATS_EN adds frameCnt and lineErr.
//
// state      | meaning
// WAIT_VSYNC | idle after reset, waiting for the first frame sync
// WAIT_LINE  | frame started, waiting for the first line sync
// ACTIVE     | capturing pixels of the current line
// FRAME_DONE | ACTIVE_Y lines captured, ignoring pixels until next vsync
module lcd_capture
   import lcd_capture_pkg::*;
#(
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
)
(
   input  logic              pxlClk,
   input  logic              rst,
   input  logic              lcdClk,
   input  logic              lcdHsync,
   input  logic              lcdVsync,
   input  logic [PIX_W-1:0]  lcdData,
   output logic [ADDR_W-1:0] wrAddr,
   output logic [35:0]       wrData,
   output logic [2:0]        wrEn,
   output logic              frameStart
`ifdef LCD_CAPTURE_STATS_EN
   ,
   output logic [7:0]        frameCnt,
   output logic              lineErr
`endif
);

   logic             strobe;
   logic             hsync_edge;
   logic             vsync_edge;
   logic [PIX_W-1:0] pix;

   lcd_sync #(
      .HSYNC_POL (HSYNC_POL),
      .VSYNC_POL (VSYNC_POL)
   ) u_sync (
      .clk        (pxlClk),
      .rst        (rst),
      .lcd_clk    (lcdClk),
      .lcd_hsync  (lcdHsync),
      .lcd_vsync  (lcdVsync),
      .lcd_data   (lcdData),
      .strobe     (strobe),
      .hsync_edge (hsync_edge),
      .vsync_edge (vsync_edge),
      .data       (pix)
   );

   state_t            state, state_n;
   logic [X_W-1:0]    x, x_n;
   logic [COL_W-1:0]  col_idx, col_n;
   slice_t            slice, slice_n;
   logic [Y_W-1:0]    y, y_n;
   logic [ADDR_W-1:0] line_base, base_n;
   logic [ADDR_W-1:0] addr_n;
   logic [35:0]       data_n;
   logic [2:0]        en_n;
   logic              fs_n;
`ifdef LCD_CAPTURE_STATS_EN
   logic [7:0]        fcnt_n;
   logic              err_n;
`endif

   // next-state and write generation; line-end handling precedes the pixel
   // of the same cycle so that pixel lands at x=0 of the new line
   always_comb begin
      state_n = state;
      x_n     = x;
      col_n   = col_idx;
      slice_n = slice;
      y_n     = y;
      base_n  = line_base;
      addr_n  = wrAddr;
      data_n  = wrData;
      en_n    = 3'b000;
      fs_n    = 1'b0;
`ifdef LCD_CAPTURE_STATS_EN
      fcnt_n  = frameCnt;
      err_n   = lineErr;
`endif
      if (vsync_edge) begin
         state_n = WAIT_LINE;
         y_n     = '0;
         base_n  = '0;
         fs_n    = 1'b1;
`ifdef LCD_CAPTURE_STATS_EN
         fcnt_n  = frameCnt + 8'd1;
         if (state == ACTIVE && x != '0) err_n = 1'b1;
`endif
      end else begin
         if (hsync_edge) begin
            case (state)
               WAIT_LINE: begin
                  state_n = ACTIVE;
                  x_n     = '0;
                  col_n   = '0;
                  slice_n = '0;
               end
               ACTIVE: begin
                  x_n     = '0;
                  col_n   = '0;
                  slice_n = '0;
                  if (x != '0) begin
                     y_n    = y + Y_W'(1);
                     base_n = line_base + ADDR_W'(COLLEN);
                     if (y_n >= Y_W'(ACTIVE_Y)) state_n = FRAME_DONE;
`ifdef LCD_CAPTURE_STATS_EN
                     if (x != X_W'(ACTIVE_X)) err_n = 1'b1;
`endif
                  end
               end
               default: ;
            endcase
         end
         // x counts every strobe (saturating) so overlong lines are visible;
         // only the first ACTIVE_X produce writes
         if (strobe && state_n == ACTIVE) begin
            if (x_n < X_W'(ACTIVE_X)) begin
               addr_n = base_n + ADDR_W'(col_n);
               data_n = {3{pix}};
               en_n   = 3'b100 >> slice_n;
               if (col_n == COL_W'(COLLEN - 1)) begin
                  col_n   = '0;
                  slice_n = slice_n + 2'd1;
               end else begin
                  col_n = col_n + COL_W'(1);
               end
            end
            if (x_n != '1) x_n = x_n + X_W'(1);
         end
      end
   end

   // state, counters and registered write port
   always_ff @(posedge pxlClk) begin
      if (rst) begin
         state      <= WAIT_VSYNC;
         x          <= '0;
         col_idx    <= '0;
         slice      <= '0;
         y          <= '0;
         line_base  <= '0;
         wrAddr     <= '0;
         wrData     <= '0;
         wrEn       <= 3'b000;
         frameStart <= 1'b0;
`ifdef LCD_CAPTURE_STATS_EN
         frameCnt   <= 8'd0;
         lineErr    <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         x          <= x_n;
         col_idx    <= col_n;
         slice      <= slice_n;
         y          <= y_n;
         line_base  <= base_n;
         wrAddr     <= addr_n;
         wrData     <= data_n;
         wrEn       <= en_n;
         frameStart <= fs_n;
`ifdef LCD_CAPTURE_STATS_EN
         frameCnt   <= fcnt_n;
         lineErr    <= err_n;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_capture.sv
// Self-checking bench for lcd_capture. Expected writes come from an
// event-level model of the framebuffer layout (address = line*COLLEN +
// x mod COLLEN, slice = x / COLLEN).
module tb_lcd_capture;

   localparam int C  = 75;
   localparam int AX = 224;
   localparam int AY = 144;

   logic        pxlClk = 1'b0;
   logic        rst;
   logic        lcdClk;
   logic        lcdHsync;
   logic        lcdVsync;
   logic [11:0] lcdData;
   logic [13:0] wrAddr;
   logic [35:0] wrData;
   logic [2:0]  wrEn;
   logic        frameStart;
`ifdef LCD_CAPTURE_STATS_EN
   logic [7:0]  frameCnt;
   logic        lineErr;
`endif

   always #5 pxlClk = ~pxlClk;

   lcd_capture dut (
      .pxlClk     (pxlClk),
      .rst        (rst),
      .lcdClk     (lcdClk),
      .lcdHsync   (lcdHsync),
      .lcdVsync   (lcdVsync),
      .lcdData    (lcdData),
      .wrAddr     (wrAddr),
      .wrData     (wrData),
      .wrEn       (wrEn),
      .frameStart (frameStart)
`ifdef LCD_CAPTURE_STATS_EN
      ,
      .frameCnt   (frameCnt),
      .lineErr    (lineErr)
`endif
   );

   typedef struct packed {
      logic [13:0] addr;
      logic [35:0] data;
      logic [2:0]  en;
   } wr_t;

   typedef struct {
      int          idx;
      logic [13:0] addr;
      logic [2:0]  en;
   } vec_t;

   wr_t exp_q[$];
   wr_t act_log[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  exp_fs = 0;
   int  act_fs = 0;
   bit  mon_en = 1'b0;

   // model state: phase 0 idle, 1 waiting for line, 2 in line, 3 frame done
   int  m_phase = 0;
   int  m_x = 0;
   int  m_y = 0;
   int  exp_fcnt = 0;
   bit  exp_err = 1'b0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void m_vsync();
      if (m_phase == 2 && m_x > 0) exp_err = 1'b1;
      m_phase  = 1;
      m_y      = 0;
      exp_fs++;
      exp_fcnt = (exp_fcnt + 1) % 256;
   endfunction

   function automatic void m_hsync();
      if (m_phase == 1) begin
         m_phase = 2;
         m_x     = 0;
      end else if (m_phase == 2) begin
         if (m_x > 0) begin
            if (m_x != AX) exp_err = 1'b1;
            m_y++;
            if (m_y >= AY) m_phase = 3;
         end
         m_x = 0;
      end
   endfunction

   function automatic void m_pixel(input logic [11:0] p);
      wr_t w;
      if (m_phase == 2) begin
         if (m_x < AX) begin
            w.addr = 14'(m_y * C + m_x % C);
            w.data = {p, p, p};
            w.en   = 3'(4 >> (m_x / C));
            exp_q.push_back(w);
         end
         m_x++;
      end
   endfunction

   function automatic void m_reset();
      m_phase  = 0;
      m_x      = 0;
      m_y      = 0;
      exp_fcnt = 0;
      exp_err  = 1'b0;
      exp_q.delete();
   endfunction

   // write monitor: scoreboard every write against the model queue
   initial begin
      wr_t a, e;
      forever begin
         @(posedge pxlClk);
         #1;
         if (mon_en) begin
            if (frameStart === 1'b1) act_fs++;
            if (wrEn !== 3'b000) begin
               a = {wrAddr, wrData, wrEn};
               act_log.push_back(a);
               if (exp_q.size() == 0) begin
                  check("unexpected_write_en", 64'(wrEn), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 64'(a.addr), 64'(e.addr));
                  check("wr_data", 64'(a.data), 64'(e.data));
                  check("wr_en", 64'(a.en), 64'(e.en));
               end
            end
         end
      end
   end

   task automatic pix(input logic [11:0] p);
      @(negedge pxlClk);
      lcdData = p;
      lcdClk  = 1'b1;
      m_pixel(p);
      repeat (2) @(negedge pxlClk);
      lcdClk = 1'b0;
      @(negedge pxlClk);
   endtask

   task automatic hs();
      @(negedge pxlClk);
      lcdHsync = 1'b1;
      m_hsync();
      repeat (3) @(negedge pxlClk);
      lcdHsync = 1'b0;
      @(negedge pxlClk);
   endtask

   task automatic vs();
      @(negedge pxlClk);
      lcdVsync = 1'b1;
      m_vsync();
      repeat (3) @(negedge pxlClk);
      lcdVsync = 1'b0;
      @(negedge pxlClk);
   endtask

   task automatic hs_pix(input logic [11:0] p);
      @(negedge pxlClk);
      lcdHsync = 1'b1;
      lcdClk   = 1'b1;
      lcdData  = p;
      m_hsync();
      m_pixel(p);
      repeat (2) @(negedge pxlClk);
      lcdClk = 1'b0;
      @(negedge pxlClk);
      lcdHsync = 1'b0;
      @(negedge pxlClk);
   endtask

   task automatic vs_pix(input logic [11:0] p);
      @(negedge pxlClk);
      lcdVsync = 1'b1;
      lcdClk   = 1'b1;
      lcdData  = p;
      m_vsync();
      m_pixel(p);
      repeat (2) @(negedge pxlClk);
      lcdClk = 1'b0;
      @(negedge pxlClk);
      lcdVsync = 1'b0;
      @(negedge pxlClk);
   endtask

   task automatic checkpoint(input string tag);
      repeat (8) @(negedge pxlClk);
      check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_frame_starts"}, 64'(act_fs), 64'(exp_fs));
`ifdef LCD_CAPTURE_STATS_EN
      check({tag, "_frame_cnt"}, 64'(frameCnt), 64'(exp_fcnt));
      check({tag, "_line_err"}, 64'(lineErr), 64'(exp_err));
`endif
   endtask

   function automatic wr_t log_at(input int k);
      wr_t r;
      r = '1;
      if (k >= 0 && k < act_log.size()) r = act_log[k];
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t tbl[5];
      int   k0;
      int   k1;
      wr_t  w;
      logic [11:0] p;

      tbl[0] = '{0,   14'd0,  3'b100};
      tbl[1] = '{74,  14'd74, 3'b100};
      tbl[2] = '{75,  14'd0,  3'b010};
      tbl[3] = '{150, 14'd0,  3'b001};
      tbl[4] = '{223, 14'd73, 3'b001};

      rst      = 1'b1;
      lcdClk   = 1'b0;
      lcdHsync = 1'b0;
      lcdVsync = 1'b0;
      lcdData  = '0;
      repeat (3) @(negedge pxlClk);
      rst = 1'b0;
      @(posedge pxlClk);
      #1;
      check("reset_wr_en", 64'(wrEn), 64'd0);
      check("reset_wr_addr", 64'(wrAddr), 64'd0);
      check("reset_wr_data", 64'(wrData), 64'd0);
      check("reset_frame_start", 64'(frameStart), 64'd0);
      mon_en = 1'b1;

      // 1: one full line with data = x, layout checked through a table
      vs();
      hs();
      k0 = act_log.size();
      for (int i = 0; i < AX; i++) pix(12'(i));
      checkpoint("t1");
      check("t1_write_count", 64'(act_log.size() - k0), 64'(AX));
      check("t1_frame_start_once", 64'(act_fs), 64'd1);
      for (int i = 0; i < 5; i++) begin
         w = log_at(k0 + tbl[i].idx);
         p = 12'(tbl[i].idx);
         check("t1_tbl_addr", 64'(w.addr), 64'(tbl[i].addr));
         check("t1_tbl_en", 64'(w.en), 64'(tbl[i].en));
         check("t1_tbl_data", 64'(w.data), 64'({p, p, p}));
      end

      // 2: full frame of short random lines, with some empty lines
      vs();
      k1 = 0;
      for (int l = 0; l < AY; l++) begin
         hs();
         if ($urandom_range(0, 7) == 0) hs();
         if (l == AY - 1) k1 = act_log.size();
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) pix(12'($urandom));
      end
      repeat (6) @(negedge pxlClk);
      w = log_at(k1);
      check("t2_line143_addr", 64'(w.addr), 64'd10725);
      check("t2_line143_en", 64'(w.en), 64'(3'b100));
      hs();
      k0 = act_log.size();
      for (int j = 0; j < 3; j++) pix(12'($urandom));
      checkpoint("t2");
      check("t2_writes_after_done", 64'(act_log.size() - k0), 64'd0);

      // 3: overlong line of 230 strobes
      @(negedge pxlClk);
      rst = 1'b1;
      @(negedge pxlClk);
      rst = 1'b0;
      m_reset();
      vs();
      hs();
      k0 = act_log.size();
      for (int i = 0; i < 230; i++) pix(12'($urandom));
      repeat (6) @(negedge pxlClk);
      check("t3_write_count", 64'(act_log.size() - k0), 64'(AX));
`ifdef LCD_CAPTURE_STATS_EN
      check("t3_line_err_before_end", 64'(lineErr), 64'd0);
`endif
      hs();
      pix(12'h5a5);
      checkpoint("t3");
      w = log_at(act_log.size() - 1);
      check("t3_next_line_addr", 64'(w.addr), 64'd75);
`ifdef LCD_CAPTURE_STATS_EN
      check("t3_line_err", 64'(lineErr), 64'd1);
`endif

      // 4: vsync in the middle of line 5
      vs();
      for (int l = 0; l < 5; l++) begin
         hs();
         pix(12'($urandom));
         pix(12'($urandom));
      end
      hs();
      for (int i = 0; i <= 10; i++) pix(12'($urandom));
      k0 = act_fs;
      vs();
      k1 = act_log.size();
      pix(12'h111);
      pix(12'h222);
      repeat (6) @(negedge pxlClk);
      check("t4_no_writes_after_vsync", 64'(act_log.size() - k1), 64'd0);
      check("t4_frame_start_pulse", 64'(act_fs - k0), 64'd1);
      hs();
      pix(12'h3c3);
      checkpoint("t4");
      w = log_at(act_log.size() - 1);
      check("t4_restart_addr", 64'(w.addr), 64'd0);

      // 5: single strobe traced cycle by cycle (x=1 of line 0)
      @(negedge pxlClk);
      lcdData = 12'habc;
      lcdClk  = 1'b1;
      m_pixel(12'habc);
      for (int c = 1; c <= 5; c++) begin
         @(posedge pxlClk);
         #1;
         if (c == 4) begin
            check("t5_wr_en_cycle4", 64'(wrEn), 64'(3'b100));
            check("t5_wr_addr_cycle4", 64'(wrAddr), 64'd1);
            check("t5_wr_data_cycle4", 64'(wrData), 64'h abcabcabc);
         end else begin
            check("t5_wr_en_idle", 64'(wrEn), 64'd0);
         end
         if (c == 2) lcdClk = 1'b0;
      end
      checkpoint("t5");

      // simultaneous events: hsync+strobe lands at x=0, vsync+strobe drops
      hs_pix(12'h777);
      checkpoint("sim_hs");
      w = log_at(act_log.size() - 1);
      check("sim_hs_addr", 64'(w.addr), 64'd75);
      check("sim_hs_en", 64'(w.en), 64'(3'b100));
      k0 = act_log.size();
      vs_pix(12'h888);
      checkpoint("sim_vs");
      check("sim_vs_dropped", 64'(act_log.size() - k0), 64'd0);

      // 6: reset mid-line
      hs();
      pix(12'h001);
      pix(12'h002);
      pix(12'h003);
      checkpoint("t6_pre");
      @(negedge pxlClk);
      rst = 1'b1;
      @(posedge pxlClk);
      #1;
      check("t6_wr_en_after_rst", 64'(wrEn), 64'd0);
      check("t6_wr_addr_after_rst", 64'(wrAddr), 64'd0);
      check("t6_frame_start_after_rst", 64'(frameStart), 64'd0);
      @(negedge pxlClk);
      rst = 1'b0;
      m_reset();
      k0 = act_log.size();
      hs();
      for (int j = 0; j < 4; j++) pix(12'($urandom));
      repeat (6) @(negedge pxlClk);
      check("t6_ignored_after_rst", 64'(act_log.size() - k0), 64'd0);
`ifdef LCD_CAPTURE_STATS_EN
      check("t6_frame_cnt_zero", 64'(frameCnt), 64'd0);
`endif
      vs();
      hs();
      pix(12'h444);
      checkpoint("t6");
      w = log_at(act_log.size() - 1);
      check("t6_resume_addr", 64'(w.addr), 64'd0);

      // randomized mix of events against the model
      for (int n = 0; n < 500; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 72)      pix(12'($urandom));
         else if (r < 88) hs();
         else if (r < 91) vs();
         else if (r < 97) hs_pix(12'($urandom));
         else             vs_pix(12'($urandom));
      end
      checkpoint("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
